// File: rtl/memory_stage_if.sv
// memory_stage_if: EX/MEM -> MEM/WB bundle of the 16-bit core's memory stage.
//   master: upstream/driver side. It drives the EX/MEM bundle and flush, and
//           observes stall_out and the MEM/WB bundle.
//   slave : the memory stage itself.
// Signals:
//   valid_in, MemRead, MemWrite, RegWriteIn, RegStoreIn, ALUResultIn,
//   storeData, rdIn, flush            (EX/MEM side, into the stage)
//   stall_out                         (combinational hold request upstream)
//   RegWrite, RegStore, ALUResult,
//   StoreMem, rdWB                    (registered MEM/WB side)
interface memory_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              valid_in;
  logic              MemRead;
  logic              MemWrite;
  logic              RegWriteIn;
  logic              RegStoreIn;
  logic [DATA_W-1:0] ALUResultIn;
  logic [DATA_W-1:0] storeData;
  logic [REG_AW-1:0] rdIn;
  logic              flush;
  logic              stall_out;
  logic              RegWrite;
  logic              RegStore;
  logic [DATA_W-1:0] ALUResult;
  logic [DATA_W-1:0] StoreMem;
  logic [REG_AW-1:0] rdWB;

  modport master (
    output valid_in, MemRead, MemWrite, RegWriteIn, RegStoreIn,
           ALUResultIn, storeData, rdIn, flush,
    input  stall_out, RegWrite, RegStore, ALUResult, StoreMem, rdWB
  );

  modport slave (
    input  valid_in, MemRead, MemWrite, RegWriteIn, RegStoreIn,
           ALUResultIn, storeData, rdIn, flush,
    output stall_out, RegWrite, RegStore, ALUResult, StoreMem, rdWB
  );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: data-memory access stage of the 16-bit core.
// Reads the EX/MEM bundle, accesses an internal word-addressed synchronous
// RAM of 2^MEM_AW words, and registers the MEM/WB bundle.
// Loads take two cycles. stall_out is raised in the issue cycle.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   bus       memory_stage_if.slave (EX/MEM in, stall_out, MEM/WB out)
//   load_cnt  completed-load counter   (only with MEM_STAGE_PERF_EN)
//   store_cnt committed-store counter  (only with MEM_STAGE_PERF_EN)
// Build option: define MEM_STAGE_PERF_EN to add the saturating counters.
module memory_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int MEM_AW = 8
) (
  input  logic        clk,
  input  logic        reset,
  memory_stage_if.slave bus
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [15:0] load_cnt,
  output logic [15:0] store_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, LOAD_WAIT = 1'b1} state_t;

  state_t              state;
  logic [MEM_AW-1:0]   addr;
  logic                liveRun;
  logic                issueLoad;
  logic                doStore;
  logic                finishLoad;

  // Load context captured at issue. The upstream bundle still shows the load
  // during LOAD_WAIT, but nothing depends on that.
  logic [REG_AW-1:0]   ldRd;
  logic                ldRegWrite;
  logic [DATA_W-1:0]   ldAlu;

  logic [DATA_W-1:0]   ram [0:(1<<MEM_AW)-1];
  logic [DATA_W-1:0]   ramQ;

  // Write-back selection always comes from the op type, so the incoming
  // select bit is carried on the bus but never consumed here.
  logic unusedRegStore;
  assign unusedRegStore = bus.RegStoreIn;

  assign addr       = bus.ALUResultIn[MEM_AW-1:0];
  assign liveRun    = (state == RUN) && bus.valid_in && !bus.flush;
  assign issueLoad  = liveRun && bus.MemRead;
  // A store asserted during reset must not land in the RAM.
  assign doStore    = liveRun && bus.MemWrite && !bus.MemRead && !reset;
  assign finishLoad = (state == LOAD_WAIT) && !bus.flush;

  assign bus.stall_out = issueLoad;

  // RAM: no reset on contents. A write at edge N is visible to a read issued
  // at edge N+1.
  always_ff @(posedge clk) begin
    if (doStore)   ram[addr] <= bus.storeData;
    if (issueLoad) ramQ      <= ram[addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      bus.RegWrite <= 1'b0;
      bus.RegStore <= 1'b0;
      bus.ALUResult <= '0;
      bus.StoreMem <= '0;
      bus.rdWB     <= '0;
      ldRd         <= '0;
      ldRegWrite   <= 1'b0;
      ldAlu        <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (!liveRun) begin
            bus.RegWrite  <= 1'b0;
            bus.RegStore  <= 1'b0;
            bus.ALUResult <= '0;
            bus.StoreMem  <= '0;
            bus.rdWB      <= '0;
          end else if (bus.MemRead) begin
            // Issue: the MEM/WB slot gets a bubble while the RAM read is in flight.
            bus.RegWrite  <= 1'b0;
            bus.RegStore  <= 1'b0;
            bus.ALUResult <= '0;
            bus.StoreMem  <= '0;
            bus.rdWB      <= '0;
            ldRd          <= bus.rdIn;
            ldRegWrite    <= bus.RegWriteIn;
            ldAlu         <= bus.ALUResultIn;
            state         <= LOAD_WAIT;
          end else begin
            // ALU op or store: pass-through. The select bit is forced to the
            // ALU path.
            bus.RegWrite  <= bus.RegWriteIn;
            bus.RegStore  <= 1'b0;
            bus.ALUResult <= bus.ALUResultIn;
            bus.StoreMem  <= '0;
            bus.rdWB      <= bus.rdIn;
          end
        end
        LOAD_WAIT: begin
          if (finishLoad) begin
            bus.RegWrite  <= ldRegWrite;
            bus.RegStore  <= 1'b1;
            bus.ALUResult <= ldAlu;
            bus.StoreMem  <= ramQ;
            bus.rdWB      <= ldRd;
          end else begin
            bus.RegWrite  <= 1'b0;
            bus.RegStore  <= 1'b0;
            bus.ALUResult <= '0;
            bus.StoreMem  <= '0;
            bus.rdWB      <= '0;
          end
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef MEM_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      if (finishLoad && (load_cnt != 16'hFFFF))  load_cnt  <= load_cnt + 16'd1;
      if (doStore    && (store_cnt != 16'hFFFF)) store_cnt <= store_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  localparam int DW = 16;
  localparam int RW = 3;
  localparam int MW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_stage_if #(.DATA_W(DW), .REG_AW(RW)) bus ();

`ifdef MEM_STAGE_PERF_EN
  logic [15:0] loadCnt, storeCnt;
`endif

  memory_stage #(.DATA_W(DW), .REG_AW(RW), .MEM_AW(MW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus)
`ifdef MEM_STAGE_PERF_EN
    ,
    .load_cnt  (loadCnt),
    .store_cnt (storeCnt)
`endif
  );

  // Reference model: word array indexed by the low address byte, plus the
  // set of addresses written so far.
  logic [DW-1:0] mdl [256];
  bit            known [256];
  logic [7:0]    knownQ [$];
  int            expLoads = 0;
  int            expStores = 0;
  int            nChk = 0;
  int            nPass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] wb(input logic rw, input logic rs, input logic [15:0] alu,
                                     input logic [15:0] sm, input logic [2:0] rd);
    return {27'b0, rw, rs, alu, sm, rd};
  endfunction

  task automatic chkWb(input string tag, input logic [63:0] exp);
    chk(tag, {27'b0, bus.RegWrite, bus.RegStore, bus.ALUResult, bus.StoreMem, bus.rdWB}, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic mr, input logic mw, input logic rwi,
                       input logic rsi, input logic [15:0] alu, input logic [15:0] sd,
                       input logic [2:0] rd, input logic fl);
    bus.valid_in    = v;
    bus.MemRead     = mr;
    bus.MemWrite    = mw;
    bus.RegWriteIn  = rwi;
    bus.RegStoreIn  = rsi;
    bus.ALUResultIn = alu;
    bus.storeData   = sd;
    bus.rdIn        = rd;
    bus.flush       = fl;
  endtask

  task automatic aluOp(input logic [15:0] alu, input logic [2:0] rd, input logic rw);
    drive(1, 0, 0, rw, 1'($urandom), alu, 16'($urandom), rd, 0);
    #1 chk("aluStall", bus.stall_out, 0);
    step();
    chkWb("alu", wb(rw, 0, alu, 0, rd));
  endtask

  task automatic storeOp(input logic [15:0] a, input logic [15:0] d, input logic [2:0] rd, input logic rw);
    drive(1, 0, 1, rw, 1'($urandom), a, d, rd, 0);
    #1 chk("stStall", bus.stall_out, 0);
    step();
    chkWb("store", wb(rw, 0, a, 0, rd));
    mdl[a[7:0]] = d;
    if (!known[a[7:0]]) knownQ.push_back(a[7:0]);
    known[a[7:0]] = 1;
    expStores++;
  endtask

  // Upstream holds the load for the wait cycle. Write-related inputs are
  // scrambled there to show they are ignored.
  task automatic loadOp(input logic [15:0] a, input logic [2:0] rd, input logic rw,
                        input logic fl, input logic mw);
    drive(1, 1, mw, rw, 1'($urandom), a, 16'($urandom), rd, 0);
    #1 chk("ldStall", bus.stall_out, 1);
    step();
    chkWb("ldBubble", 0);
    bus.flush     = fl;
    bus.MemWrite  = 1'($urandom);
    bus.storeData = 16'($urandom);
    #1 chk("waitStall", bus.stall_out, 0);
    step();
    if (fl) chkWb("ldFlush", 0);
    else begin
      chkWb("ldData", wb(rw, 1, a, mdl[a[7:0]], rd));
      expLoads++;
    end
  endtask

  // Bubble in RUN: either not valid or flushed; any memory op is killed.
  task automatic killOp(input logic useFlush);
    drive(!useFlush ? 1'b0 : 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          16'($urandom), 16'($urandom), 3'($urandom), useFlush);
    #1 chk("killStall", bus.stall_out, 0);
    step();
    chkWb("kill", 0);
  endtask

  initial begin
    logic [15:0] a;
    for (int i = 0; i < 256; i++) known[i] = 0;
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chkWb("rstInit", 0);
    chk("rstInitStall", bus.stall_out, 0);
    reset = 0;

    // Store under reset must not reach the RAM.
    storeOp(16'h0040, 16'h1357, 3'd1, 1);
    reset = 1;
    drive(1, 0, 1, 1, 0, 16'h0040, 16'hCAFE, 3'd2, 0);
    #1 chk("rstStall", bus.stall_out, 0);
    step(); step();
    chkWb("rstOut", 0);
    reset = 0;
    expLoads = 0;
    expStores = 0;
    loadOp(16'h0040, 3'd4, 1, 0, 0);

    aluOp(16'h1234, 3'd5, 1);
    storeOp(16'h0010, 16'hBEEF, 3'd0, 0);
    loadOp(16'h0010, 3'd3, 1, 0, 0);

    storeOp(16'h0001, 16'h1111, 3'd0, 0);
    storeOp(16'h0002, 16'h2222, 3'd0, 0);
    loadOp(16'h0001, 3'd6, 1, 0, 0);
    loadOp(16'h0002, 3'd7, 1, 0, 1);  // MemWrite also set: treated as a load only
    loadOp(16'h0002, 3'd7, 1, 0, 0);

    loadOp(16'h0001, 3'd2, 1, 1, 0);  // flushed in LOAD_WAIT
    aluOp(16'h5A5A, 3'd2, 1);

    storeOp(16'h0105, 16'h00AA, 3'd0, 0);
    loadOp(16'h0005, 3'd1, 1, 0, 0);

    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      a = {8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
      if (kind <= 1) aluOp(16'($urandom), 3'($urandom), 1'($urandom));
      else if (kind <= 4) storeOp(a, 16'($urandom), 3'($urandom), 1'($urandom));
      else if (kind <= 7) begin
        a[7:0] = knownQ[$urandom_range(0, knownQ.size() - 1)];
        loadOp(a, 3'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom));
      end
      else killOp(1'($urandom));
    end

`ifdef MEM_STAGE_PERF_EN
    chk("storeCnt", storeCnt, expStores);
    chk("loadCnt", loadCnt, expLoads);
`endif

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
